addsub_rr_arbiter: RTL

//  Shares one 16-bit Kogge-Stone add/subtract datapath between NREQ requesters
//  (butterfly add/sub lanes of the 64-point FFT). Arbitration is round-robin.

---
 rtl/addsub_rr_arbiter.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/addsub_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ksa_top_16b
//  Purpose  : 16-bit Kogge-Stone parallel-prefix adder with carry-in.
//             sum = a + b + c0 (mod 2^16), cout = carry out of bit 15.
//  Ports    : a, b  [15:0]  in   operands
//             c0            in   carry-in
//             sum   [15:0]  out  a + b + c0, low 16 bits
//             cout          out  carry out of the MSB
//  Revision : 1.0  initial release
// ============================================================================
module ksa_top_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c0,
    output logic [15:0] sum,
    output logic        cout
);

    localparam int c_WIDTH  = 16;
    localparam int c_LEVELS = 4;   // log2(16) prefix stages

    // Prefix tree as a function so every stage's vectors stay local and no
    // stage-to-stage combinational feedback is visible at module level.
    // Returns {cout, sum}.
    function automatic logic [c_WIDTH:0] f_ksa(
        input logic [c_WIDTH-1:0] fa,
        input logic [c_WIDTH-1:0] fb,
        input logic               fc0
    );
        logic [c_WIDTH-1:0] v_p0;
        logic [c_WIDTH-1:0] v_g;
        logic [c_WIDTH-1:0] v_p;
        logic [c_WIDTH-1:0] v_g_nxt;
        logic [c_WIDTH-1:0] v_p_nxt;
        logic [c_WIDTH-1:0] v_carry;
        int                 v_dist;

        v_p0 = fa ^ fb;
        v_g  = fa & fb;
        v_p  = v_p0;
        // Folding the carry-in into bit 0's generate lets every group
        // generate G[i:0] already account for c0, so carry into bit i+1
        // is simply the final G[i].
        v_g[0] = v_g[0] | (v_p0[0] & fc0);

        for (int lvl = 0; lvl < c_LEVELS; lvl++) begin
            v_dist  = 1 << lvl;
            v_g_nxt = v_g;
            v_p_nxt = v_p;
            for (int i = 0; i < c_WIDTH; i++) begin
                if (i >= v_dist) begin
                    v_g_nxt[i] = v_g[i] | (v_p[i] & v_g[i-v_dist]);
                    v_p_nxt[i] = v_p[i] & v_p[i-v_dist];
                end
            end
            v_g = v_g_nxt;
            v_p = v_p_nxt;
        end

        v_carry = {v_g[c_WIDTH-2:0], fc0};
        return {v_g[c_WIDTH-1], v_p0 ^ v_carry};
    endfunction

    logic [c_WIDTH:0] w_res;

    assign w_res = f_ksa(a, b, c0);
    assign sum   = w_res[c_WIDTH-1:0];
    assign cout  = w_res[c_WIDTH];

endmodule

// ============================================================================
//  Module   : addsub_rr_arbiter
//  Purpose  : Round-robin arbiter sharing one 16-bit Kogge-Stone add/subtract
//             datapath between NREQ valid/ready requesters. Results leave
//             through a one-entry registered, back-pressurable slot tagged
//             with the index of the requester that produced them.
//  Ports    : clk                    in   system clock, rising edge
//             rst_n                  in   asynchronous active-low reset
//             req_valid [NREQ]       in   requester i has operands pending
//             req_ready [NREQ]       out  requester i accepted (one-hot or 0)
//             req_sub   [NREQ]       in   1 = A-B, 0 = A+B per requester
//             req_a     [NREQ*16]    in   operand A, requester i at [16*i +: 16]
//             req_b     [NREQ*16]    in   operand B, requester i at [16*i +: 16]
//             res_valid              out  result slot holds a result
//             res_ready              in   downstream consumes the result
//             res_data  [16]         out  sum/difference modulo 2^16
//             res_cout               out  carry out (sub: 1 = no borrow)
//             res_id    [IDW]        out  requester index of res_data
//             op_count  [16]         out  accepted operations, saturating
//  Revision : 1.0  initial release
// ============================================================================
module addsub_rr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 16,   // datapath is a fixed 16-bit adder
    parameter int IDW        = 2     // $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_sub,
    input  logic [NREQ*DATA_WIDTH-1:0] req_a,
    input  logic [NREQ*DATA_WIDTH-1:0] req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic                       res_cout,
    output logic [IDW-1:0]             res_id,
    output logic [15:0]                op_count
);

    localparam logic [IDW-1:0] c_LAST_ID   = IDW'(NREQ - 1);
    localparam logic [15:0]    c_COUNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_res_cout;
    logic [IDW-1:0]        r_res_id;
    logic [15:0]           r_op_count;
    logic [IDW-1:0]        r_rr_ptr;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_a_arr [NREQ];
    logic [DATA_WIDTH-1:0] w_b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin grant
    //   Rotating the request vector right by rr_ptr puts the highest
    //   priority requester at bit 0; the lowest set bit of the rotated
    //   vector is then the winner, offset back by rr_ptr modulo NREQ.
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic              w_found;
    logic [IDW-1:0]    w_grant;
    logic [IDW:0]      w_grant_sum;

    assign w_req_dbl = {req_valid, req_valid} >> r_rr_ptr;
    assign w_req_rot = w_req_dbl[NREQ-1:0];

    always_comb begin
        w_found     = 1'b0;
        w_grant     = '0;
        w_grant_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found     = 1'b1;
                w_grant_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                // Wrap without a divider: the sum is below 2*NREQ.
                if (w_grant_sum >= (IDW+1)'(NREQ)) begin
                    w_grant_sum = w_grant_sum - (IDW+1)'(NREQ);
                end
                w_grant = w_grant_sum[IDW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    //   The output slot can take a new result when it is empty or being
    //   drained this cycle. req_ready is held low during reset even though
    //   the slot reads empty then.
    // ------------------------------------------------------------------
    logic            w_can_issue;
    logic            w_transfer;
    logic [NREQ-1:0] w_grant_onehot;

    assign w_can_issue    = ~r_res_valid | res_ready;
    assign w_transfer     = w_found & w_can_issue & rst_n;
    assign w_grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_grant;
    assign req_ready      = w_transfer ? w_grant_onehot : '0;

    // ------------------------------------------------------------------
    // Shared datapath: subtract is A + ~B + 1
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic                  w_op_sub;
    logic [DATA_WIDTH-1:0] w_b_inv;
    logic [DATA_WIDTH-1:0] w_b_eff;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_cout;

    assign w_op_a   = w_a_arr[w_grant];
    assign w_op_b   = w_b_arr[w_grant];
    assign w_op_sub = req_sub[w_grant];
    assign w_b_inv  = ~w_op_b;
    assign w_b_eff  = w_op_sub ? w_b_inv : w_op_b;

    ksa_top_16b u_ksa (
        .a    (w_op_a),
        .b    (w_b_eff),
        .c0   (w_op_sub),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // Result slot, priority pointer and operation counter
    //   The data registers load only on transfer, so res_data/res_id have
    //   no path from res_ready other than through the load enable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
            r_op_count  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_transfer) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_sum;
            r_res_cout  <= w_cout;
            r_res_id    <= w_grant;
            r_rr_ptr    <= (w_grant == c_LAST_ID) ? '0 : w_grant + 1'b1;
            if (r_op_count != c_COUNT_MAX) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire
